// File: rtl/profiler_pkg.sv
// -----------------------------------------------------------------------------
// profiler_pkg
// Shared constants and types for the stall-counter UART readout.
//   NUM_COUNTERS / COUNTER_W : shape of the counter bank coming from stall_unit
//   SYNC_BYTE                : first byte of every frame
//   PAYLOAD_BYTES            : counter bytes per frame (36)
//   LAST_PAYLOAD_IDX         : byte-index value of the final payload byte
//   tx_state_t               : readout FSM states (also exported for debug)
// -----------------------------------------------------------------------------
package profiler_pkg;

    localparam int NUM_COUNTERS  = 9;
    localparam int COUNTER_W     = 32;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam int PAYLOAD_BYTES = NUM_COUNTERS * COUNTER_W / 8;
    localparam logic [5:0] LAST_PAYLOAD_IDX = 6'(PAYLOAD_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        PAYLOAD,
        CHECKSUM,
        FINISH
    } tx_state_t;

endpackage

// File: rtl/stall_counter_uart_tx_if.sv
// -----------------------------------------------------------------------------
// stall_counter_uart_tx_if
// Bundles the request/counter inputs and the serial/status outputs of the
// stall-counter UART readout.
//   start       : request one frame (only honoured while the FSM is IDLE)
//   counters    : live counter bank, [NUM_COUNTERS-1:0][COUNTER_W-1:0]
//   uart_txd    : serial line, idle high
//   busy        : frame in progress
//   done        : one-cycle pulse when a frame has fully left the line
//   frames_sent : completed-frame count, wraps at 16 bits
//   state       : current FSM state, for debug and checkers
// Modports: master = the side issuing requests, slave = the readout block.
// -----------------------------------------------------------------------------
interface stall_counter_uart_tx_if;
    import profiler_pkg::*;

    logic                                       start;
    logic [NUM_COUNTERS-1:0][COUNTER_W-1:0]     counters;
    logic                                       uart_txd;
    logic                                       busy;
    logic                                       done;
    logic [15:0]                                frames_sent;
    tx_state_t                                  state;

    modport master (
        output start, counters,
        input  uart_txd, busy, done, frames_sent, state
    );

    modport slave (
        input  start, counters,
        output uart_txd, busy, done, frames_sent, state
    );

endinterface

// File: rtl/uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// 8N1 serializer for one byte at a time.
// Parameters:
//   CLKS_PER_BIT : clock cycles per serial bit (>= 2)
// Ports:
//   clk, rst  : system clock, synchronous active-high reset
//   i_valid   : i_data holds a byte to send
//   i_data    : byte to send, LSB first
//   o_ready   : serializer can take a byte this cycle
//   o_txd     : serial line (registered), idle high
// Handshake: a byte is taken on the rising edge where i_valid && o_ready.
// o_ready is high while idle and also during the last cycle of a stop bit,
// so a byte offered then starts its start bit right after the stop bit,
// with no idle gap.
// -----------------------------------------------------------------------------
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_txd
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);
    localparam logic [3:0]    LAST_BIT = 4'd9;

    // Bit 0 of r_shift is the line. It refills with ones so the line
    // rests high once the stop bit has gone out.
    logic [9:0]    r_shift;
    logic [CW-1:0] r_clk_cnt;
    logic [3:0]    r_bit_cnt;
    logic          r_active;

    logic w_bit_end;
    logic w_last;
    logic w_accept;

    assign w_bit_end = (r_clk_cnt == LAST_CLK);
    assign w_last    = r_active && w_bit_end && (r_bit_cnt == LAST_BIT);
    assign o_ready   = !r_active || w_last;
    assign w_accept  = i_valid && o_ready;
    assign o_txd     = r_shift[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift   <= '1;
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_active  <= 1'b0;
        end else if (w_accept) begin
            r_shift   <= {1'b1, i_data, 1'b0};
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            r_active  <= 1'b1;
        end else if (r_active) begin
            if (w_bit_end) begin
                r_clk_cnt <= '0;
                if (r_bit_cnt == LAST_BIT) begin
                    r_active <= 1'b0;
                end else begin
                    r_shift   <= {1'b1, r_shift[9:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else begin
                r_clk_cnt <= r_clk_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stall_counter_uart_tx.sv
// -----------------------------------------------------------------------------
// stall_counter_uart_tx
// Snapshots the nine stall/misprediction counters on request and sends them
// as one UART frame: 0xA5, then counter0..counter8 each LSB byte first,
// then (optionally) an 8-bit checksum of the 36 payload bytes.
// Parameters:
//   CLOCK_FREQ : system clock in Hz
//   BAUD_RATE  : serial bit rate; CLOCK_FREQ/BAUD_RATE must be >= 2
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   bus      : stall_counter_uart_tx_if.slave (start, counters, uart_txd,
//              busy, done, frames_sent, state)
// Build option:
//   PROFILER_TX_CHECKSUM_EN : when defined, append a checksum byte (sum
//   mod 256 of the payload bytes, sync byte excluded).
// -----------------------------------------------------------------------------
module stall_counter_uart_tx
    import profiler_pkg::*;
#(
    parameter int CLOCK_FREQ = 1000000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic                    clk,
    input  logic                    rst,
    stall_counter_uart_tx_if.slave  bus
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("stall_counter_uart_tx: CLOCK_FREQ/BAUD_RATE must be at least 2");
    end

    tx_state_t                          r_state;
    logic [NUM_COUNTERS*COUNTER_W-1:0]  r_snap;
    logic [5:0]                         r_idx;
    logic                               r_drain;
    logic                               r_busy;
    logic                               r_done;
    logic [15:0]                        r_frames_sent;
`ifdef PROFILER_TX_CHECKSUM_EN
    logic [7:0]                         r_sum;
`endif

    logic       w_tx_valid;
    logic       w_tx_ready;
    logic       w_accept;
    logic       w_frame_end;
    logic [7:0] w_tx_data;
    logic [7:0] w_payload_byte;
    logic       w_tx_txd;

    // Snapshot is flat with counter0 in the low bits, so byte n of the
    // payload is simply bits [8n+7:8n].
    assign w_payload_byte = r_snap[{r_idx, 3'b000} +: 8];
    assign w_accept       = w_tx_valid && w_tx_ready;
    // r_drain marks "last byte handed over, waiting for its stop bit";
    // the serializer's ready in that state means the stop bit is ending.
    assign w_frame_end    = r_drain && w_tx_ready;

    always_comb begin
        w_tx_valid = 1'b0;
        w_tx_data  = SYNC_BYTE;
        case (r_state)
            SYNC: begin
                w_tx_valid = 1'b1;
            end
            PAYLOAD: begin
                w_tx_valid = !r_drain;
                w_tx_data  = w_payload_byte;
            end
`ifdef PROFILER_TX_CHECKSUM_EN
            CHECKSUM: begin
                w_tx_valid = !r_drain;
                w_tx_data  = r_sum;
            end
`endif
            default: begin
                w_tx_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_snap        <= '0;
            r_idx         <= '0;
            r_drain       <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_frames_sent <= '0;
`ifdef PROFILER_TX_CHECKSUM_EN
            r_sum         <= '0;
`endif
        end else begin
            r_done <= 1'b0;
            if (w_frame_end) begin
                r_state       <= FINISH;
                r_drain       <= 1'b0;
                r_busy        <= 1'b0;
                r_done        <= 1'b1;
                r_frames_sent <= r_frames_sent + 16'd1;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start) begin
                            r_snap  <= bus.counters;
                            r_idx   <= '0;
                            r_drain <= 1'b0;
                            r_busy  <= 1'b1;
`ifdef PROFILER_TX_CHECKSUM_EN
                            r_sum   <= '0;
`endif
                            r_state <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (w_accept) begin
                            r_state <= PAYLOAD;
                        end
                    end
                    PAYLOAD: begin
                        if (w_accept) begin
`ifdef PROFILER_TX_CHECKSUM_EN
                            r_sum <= r_sum + w_payload_byte;
`endif
                            if (r_idx == LAST_PAYLOAD_IDX) begin
`ifdef PROFILER_TX_CHECKSUM_EN
                                r_state <= CHECKSUM;
`else
                                r_drain <= 1'b1;
`endif
                            end else begin
                                r_idx <= r_idx + 6'd1;
                            end
                        end
                    end
`ifdef PROFILER_TX_CHECKSUM_EN
                    CHECKSUM: begin
                        if (w_accept) begin
                            r_drain <= 1'b1;
                        end
                    end
`endif
                    FINISH: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_tx (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_tx_valid),
        .i_data  (w_tx_data),
        .o_ready (w_tx_ready),
        .o_txd   (w_tx_txd)
    );

    assign bus.uart_txd    = w_tx_txd;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.frames_sent = r_frames_sent;
    assign bus.state       = r_state;

endmodule
